decode_stage: RTL and testbench

//  Registered ID stage of the 5-stage MIPS pipeline: latches the IF instruction, decodes it
//  (R-type, I-type ALU, lw/sw, beq, lui), and holds it until RAW hazards clear.
//  A per-register pending-write scoreboard stalls issue to EX while a source has an

---
 rtl/mips_pkg.sv | 135 +++++++++++++
 rtl/reg_scoreboard.sv | 58 +++++
 rtl/decode_stage.sv | 109 ++++++++++
 tb/tb_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operation codes,
// the decoded-instruction record and the pure decode function used by the ID stage.
package mips_pkg;

    localparam int ALU_OP_W = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP = 6'd0,
        ALU_ADD = 6'd1,
        ALU_SUB = 6'd2,
        ALU_AND = 6'd3,
        ALU_OR  = 6'd4,
        ALU_SLT = 6'd5,
        ALU_SLL = 6'd6,
        ALU_LUI = 6'd7
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wd;
        logic        require_rs;
        logic        require_rt;
        logic        reg_write;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illegal;
    } decoded_t;

    // wd is zero for instructions that write nothing; sll carries its shift amount in imm.
    function automatic decoded_t decode(input logic [31:0] ir);
        decoded_t   d;
        logic [4:0] dest;
        logic       writes;
        d            = '0;
        d.rs         = ir[25:21];
        d.rt         = ir[20:16];
        d.alu_op     = ALU_NOP;
        dest         = 5'd0;
        writes       = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                dest         = ir[15:11];
                writes       = 1'b1;
                d.require_rs = 1'b1;
                d.require_rt = 1'b1;
                case (ir[5:0])
                    FN_ADD: d.alu_op = ALU_ADD;
                    FN_SUB: d.alu_op = ALU_SUB;
                    FN_AND: d.alu_op = ALU_AND;
                    FN_OR:  d.alu_op = ALU_OR;
                    FN_SLT: d.alu_op = ALU_SLT;
                    FN_SLL: begin
                        d.alu_op     = ALU_SLL;
                        d.require_rs = 1'b0;
                        d.imm        = {27'd0, ir[10:6]};
                    end
                    default: begin
                        d.illegal    = 1'b1;
                        writes       = 1'b0;
                        d.require_rs = 1'b0;
                        d.require_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                dest         = ir[20:16];
                writes       = 1'b1;
                d.require_rs = 1'b1;
                d.imm        = {{16{ir[15]}}, ir[15:0]};
                d.alu_op     = (ir[31:26] == OP_ADDI) ? ALU_ADD : ALU_SLT;
            end
            OP_ANDI, OP_ORI: begin
                dest         = ir[20:16];
                writes       = 1'b1;
                d.require_rs = 1'b1;
                d.imm        = {16'd0, ir[15:0]};
                d.alu_op     = (ir[31:26] == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LUI: begin
                dest     = ir[20:16];
                writes   = 1'b1;
                d.imm    = {ir[15:0], 16'd0};
                d.alu_op = ALU_LUI;
            end
            OP_LW: begin
                dest         = ir[20:16];
                writes       = 1'b1;
                d.require_rs = 1'b1;
                d.imm        = {{16{ir[15]}}, ir[15:0]};
                d.alu_op     = ALU_ADD;
                d.mem_rd     = 1'b1;
            end
            OP_SW: begin
                d.require_rs = 1'b1;
                d.require_rt = 1'b1;
                d.imm        = {{16{ir[15]}}, ir[15:0]};
                d.alu_op     = ALU_ADD;
                d.mem_wr     = 1'b1;
            end
            OP_BEQ: begin
                d.require_rs = 1'b1;
                d.require_rt = 1'b1;
                d.imm        = {{16{ir[15]}}, ir[15:0]};
                d.alu_op     = ALU_SUB;
                d.branch     = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        d.wd        = writes ? dest : 5'd0;
        d.reg_write = writes && (dest != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback decrements,
// with combinational busy/full queries for three register indices.
module reg_scoreboard #(
    parameter int NREG     = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_en,
    input  logic [$clog2(NREG)-1:0]  inc_idx,
    input  logic                     dec_en,
    input  logic [$clog2(NREG)-1:0]  dec_idx,
    input  logic [$clog2(NREG)-1:0]  query_a,
    input  logic [$clog2(NREG)-1:0]  query_b,
    input  logic [$clog2(NREG)-1:0]  query_w,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic                     full_w
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][SB_CNT_W-1:0] cnt_all;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
        if (gi == 0) begin : g_zero
            // r0 is hard-wired, so it never has a write outstanding.
            assign cnt_all[gi] = '0;
        end else begin : g_reg
            logic [SB_CNT_W-1:0] cnt_reg;
            logic                inc_hit;
            logic                dec_hit;

            assign inc_hit = inc_en && (inc_idx == IDX_W'(gi));
            assign dec_hit = dec_en && (dec_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (inc_hit && !dec_hit) begin
                    cnt_reg <= cnt_reg + SB_CNT_W'(1);
                end else if (dec_hit && !inc_hit && (cnt_reg != '0)) begin
                    cnt_reg <= cnt_reg - SB_CNT_W'(1);
                end
            end

            a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                !(dec_hit && !inc_hit && (cnt_reg == '0)));

            assign cnt_all[gi] = cnt_reg;
        end
    end

    assign busy_a = (cnt_all[query_a] != '0);
    assign busy_b = (cnt_all[query_b] != '0);
    assign full_w = (cnt_all[query_w] == CNT_MAX);

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: holds one instruction from IF, decodes it and issues to EX only
// when no source has an outstanding write and the destination counter has room.
module decode_stage #(
    parameter int NREG     = 32,
    parameter int SB_CNT_W = 2,
    parameter int ALU_OP_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [31:0]         if_ir,
    input  logic [31:0]         if_pc,
    output logic                id_ready,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          wd,
    output logic                require_rs,
    output logic                require_rt,
    output logic                reg_write,
    output logic [31:0]         imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                branch,
    output logic                illegal,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd
);
    import mips_pkg::*;

    logic        held_valid_reg;
    logic [31:0] ir_reg;
    logic [31:0] pc_reg;
    decoded_t    dec;
    logic        busy_rs;
    logic        busy_rt;
    logic        full_wd;
    logic        hazard;
    logic        issue;

    // Decoded fields read as zero whenever nothing is held.
    always_comb begin
        dec = '0;
        if (held_valid_reg) begin
            dec = decode(ir_reg);
        end
    end

    reg_scoreboard #(
        .NREG     (NREG),
        .SB_CNT_W (SB_CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en   (issue && dec.reg_write),
        .inc_idx  (dec.wd),
        .dec_en   (wb_valid),
        .dec_idx  (wb_rd),
        .query_a  (dec.rs),
        .query_b  (dec.rt),
        .query_w  (dec.wd),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt),
        .full_w   (full_wd)
    );

    assign hazard   = (dec.require_rs && busy_rs)
                    || (dec.require_rt && busy_rt)
                    || (dec.reg_write && full_wd);
    assign id_valid = held_valid_reg && !hazard && !flush;
    assign issue    = id_valid && ex_ready;
    assign id_ready = !held_valid_reg || issue || flush;

    // A flush wins over a same-cycle IF transfer: IF is being redirected too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_reg <= 1'b0;
            ir_reg         <= '0;
            pc_reg         <= '0;
        end else if (flush) begin
            held_valid_reg <= 1'b0;
        end else if (if_valid && id_ready) begin
            held_valid_reg <= 1'b1;
            ir_reg         <= if_ir;
            pc_reg         <= if_pc;
        end else if (issue) begin
            held_valid_reg <= 1'b0;
        end
    end

    assign id_pc      = pc_reg;
    assign rs         = dec.rs;
    assign rt         = dec.rt;
    assign wd         = dec.wd;
    assign require_rs = dec.require_rs;
    assign require_rt = dec.require_rt;
    assign reg_write  = dec.reg_write;
    assign imm        = dec.imm;
    assign alu_op     = ALU_OP_W'(dec.alu_op);
    assign mem_rd     = dec.mem_rd;
    assign mem_wr     = dec.mem_wr;
    assign branch     = dec.branch;
    assign illegal    = dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted instructions queue their expected decode,
// a negedge monitor predicts stalls from a pending-write count model and checks outputs.
module tb_decode_stage;
    import mips_pkg::*;

    localparam int CNT_MAX = 3;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wd;
        logic        req_rs;
        logic        req_rt;
        logic        rw;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  rs, rt, wd;
    logic        require_rs, require_rt, reg_write;
    logic [31:0] imm;
    logic [5:0]  alu_op;
    logic        mem_rd, mem_wr, branch, illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   pend[32];
    exp_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.NREG(32), .SB_CNT_W(2), .ALU_OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id_pc(id_pc), .rs(rs), .rt(rt), .wd(wd), .require_rs(require_rs),
        .require_rt(require_rt), .reg_write(reg_write), .imm(imm), .alu_op(alu_op),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, t, d, sh);
        return {6'd0, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Reference decode written from the instruction-set rules with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        int         i16;
        logic [4:0] dest;
        bit         writes;
        op = ir[31:26];
        fn = ir[5:0];
        i16 = int'(ir[15:0]);
        e = '0;
        e.rs = ir[25:21];
        e.rt = ir[20:16];
        e.pc = pc;
        dest = 5'd0;
        writes = 0;
        e.ill = 1'b1;
        if (op == OP_RTYPE) begin
            if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT) begin
                e.ill = 1'b0; writes = 1; dest = ir[15:11]; e.req_rs = 1'b1; e.req_rt = 1'b1;
                if (fn == FN_ADD) e.alu = ALU_ADD;
                else if (fn == FN_SUB) e.alu = ALU_SUB;
                else if (fn == FN_AND) e.alu = ALU_AND;
                else if (fn == FN_OR) e.alu = ALU_OR;
                else e.alu = ALU_SLT;
            end else if (fn == FN_SLL) begin
                e.ill = 1'b0; writes = 1; dest = ir[15:11]; e.req_rt = 1'b1;
                e.alu = ALU_SLL; e.imm = 32'(ir[10:6]);
            end
        end else if (op == OP_ADDI || op == OP_SLTI || op == OP_LW) begin
            e.ill = 1'b0; writes = 1; dest = ir[20:16]; e.req_rs = 1'b1;
            e.imm = (i16 >= 32768) ? i16 - 65536 : i16;
            e.alu = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            e.mrd = (op == OP_LW);
        end else if (op == OP_ANDI || op == OP_ORI) begin
            e.ill = 1'b0; writes = 1; dest = ir[20:16]; e.req_rs = 1'b1;
            e.imm = i16;
            e.alu = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        end else if (op == OP_LUI) begin
            e.ill = 1'b0; writes = 1; dest = ir[20:16];
            e.imm = i16 * 65536;
            e.alu = ALU_LUI;
        end else if (op == OP_SW || op == OP_BEQ) begin
            e.ill = 1'b0; e.req_rs = 1'b1; e.req_rt = 1'b1;
            e.imm = (i16 >= 32768) ? i16 - 65536 : i16;
            e.alu = (op == OP_SW) ? ALU_ADD : ALU_SUB;
            e.mwr = (op == OP_SW);
            e.br  = (op == OP_BEQ);
        end
        e.wd = writes ? dest : 5'd0;
        e.rw = writes && (dest != 5'd0);
        return e;
    endfunction

    // Monitor: predicts hazards from pending counts and checks every cycle.
    bit   m_held, m_haz, m_valid, m_issue;
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_id_valid", id_valid, 0);
            chk("rst_id_ready", id_ready, 1);
            chk("rst_id_pc", id_pc, 0);
            chk("rst_imm", imm, 0);
            chk("rst_reg_write", reg_write, 0);
            chk("rst_alu_op", alu_op, 0);
        end else begin
            m_held = (q.size() != 0);
            m_e = '0;
            if (m_held) m_e = q[0];
            m_haz = m_held && ((m_e.req_rs && m_e.rs != 0 && pend[m_e.rs] > 0)
                            || (m_e.req_rt && m_e.rt != 0 && pend[m_e.rt] > 0)
                            || (m_e.rw && pend[m_e.wd] >= CNT_MAX));
            m_valid = m_held && !m_haz && !flush;
            m_issue = m_valid && ex_ready;
            chk("id_valid", id_valid, m_valid);
            chk("id_ready", id_ready, !m_held || m_issue || flush);
            if (m_held) begin
                chk("id_pc", id_pc, m_e.pc);
                chk("rs", rs, m_e.rs);
                chk("rt", rt, m_e.rt);
                chk("wd", wd, m_e.wd);
                chk("require_rs", require_rs, m_e.req_rs);
                chk("require_rt", require_rt, m_e.req_rt);
                chk("reg_write", reg_write, m_e.rw);
                chk("imm", imm, m_e.imm);
                chk("alu_op", alu_op, m_e.alu);
                chk("mem_rd", mem_rd, m_e.mrd);
                chk("mem_wr", mem_wr, m_e.mwr);
                chk("branch", branch, m_e.br);
                chk("illegal", illegal, m_e.ill);
            end
            if (m_issue) begin
                $display("issue pc=%08h rs=%0d rt=%0d wd=%0d rw=%0d imm=%08h alu=%0d ill=%0d",
                         m_e.pc, m_e.rs, m_e.rt, m_e.wd, m_e.rw, m_e.imm, m_e.alu, m_e.ill);
                if (m_e.rw) pend[m_e.wd]++;
            end
            if (m_held && (m_issue || flush)) void'(q.pop_front());
            if (wb_valid && wb_rd != 0 && pend[wb_rd] > 0) pend[wb_rd]--;
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [31:0] ir, pc, input logic fl, er, wv,
                        input logic [4:0] wr, output bit took);
        if_valid = v; if_ir = ir; if_pc = pc; flush = fl;
        ex_ready = er; wb_valid = wv; wb_rd = wr;
        @(negedge clk);
        took = v && id_ready && !fl;
        @(posedge clk);
        if (took) q.push_back(ref_decode(ir, pc));
        #1;
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(0, 32'd0, 32'd0, 0, 1, 0, 5'd0, t);
    endtask

    task automatic retire(input logic [4:0] r);
        bit t;
        step(0, 32'd0, 32'd0, 0, 1, 1, r, t);
    endtask

    // Present ir until accepted; rnd adds random backpressure, flushes and writebacks.
    task automatic send(input logic [31:0] ir, input logic [31:0] pc, input bit rnd);
        bit         took;
        int         n;
        int         cands[$];
        logic       er, fl, wv;
        logic [4:0] wr;
        took = 0;
        n = 0;
        while (!took && n < 200) begin
            er = 1; fl = 0; wv = 0; wr = 5'd0;
            if (rnd) begin
                er = ($urandom_range(0, 99) < 75);
                fl = ($urandom_range(0, 99) < 5);
                cands.delete();
                for (int r = 1; r < 32; r++) if (pend[r] > 0) cands.push_back(r);
                if (cands.size() > 0 && $urandom_range(0, 99) < 40) begin
                    wv = 1;
                    wr = 5'(cands[$urandom_range(0, cands.size() - 1)]);
                end
            end
            step(1, ir, pc, fl, er, wv, wr, took);
            n++;
        end
        chk("accept", 32'(took), 1);
    endtask

    function automatic logic [31:0] rand_instr();
        int         k;
        logic [4:0] a, b, c;
        logic [15:0] im;
        k  = $urandom_range(0, 15);
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        case (k)
            0:  return enc_r(FN_ADD, a, b, c, 5'd0);
            1:  return enc_r(FN_SUB, a, b, c, 5'd0);
            2:  return enc_r(FN_AND, a, b, c, 5'd0);
            3:  return enc_r(FN_OR,  a, b, c, 5'd0);
            4:  return enc_r(FN_SLT, a, b, c, 5'd0);
            5:  return enc_r(FN_SLL, a, b, c, im[4:0]);
            6:  return enc_i(OP_ADDI, a, b, im);
            7:  return enc_i(OP_SLTI, a, b, im);
            8:  return enc_i(OP_ANDI, a, b, im);
            9:  return enc_i(OP_ORI,  a, b, im);
            10: return enc_i(OP_LUI,  a, b, im);
            11: return enc_i(OP_LW,   a, b, im);
            12: return enc_i(OP_SW,   a, b, im);
            13: return enc_i(OP_BEQ,  a, b, im);
            14: return enc_r(6'h3E, a, b, c, 5'd0);
            default: return enc_i(6'h3F, a, b, im);
        endcase
    endfunction

    initial begin
        bit t;
        foreach (pend[i]) pend[i] = 0;
        rst_n = 0; if_valid = 0; if_ir = 0; if_pc = 0; flush = 0;
        ex_ready = 0; wb_valid = 0; wb_rd = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // addi r1 issues, then add r2,r1,r1 stalls until r1 is written back
        send(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5), 32'h100, 0);
        send(enc_r(FN_ADD, 5'd1, 5'd1, 5'd2, 5'd0), 32'h104, 0);
        idle(3);
        retire(5'd1);
        idle(1);
        retire(5'd2);

        // four loads to r3: the fourth waits for a free counter slot
        for (int i = 0; i < 4; i++) send(enc_i(OP_LW, 5'd0, 5'd3, 16'(4 * i)), 32'h200 + 32'(4 * i), 0);
        idle(2);
        retire(5'd3);
        idle(1);
        for (int i = 0; i < 3; i++) retire(5'd3);

        // writer to r4 issuing while r4 retires leaves its count at 1
        send(enc_i(OP_ADDI, 5'd0, 5'd4, 16'd1), 32'h300, 0);
        idle(1);
        send(enc_i(OP_ADDI, 5'd0, 5'd4, 16'd2), 32'h304, 0);
        step(0, 32'd0, 32'd0, 0, 1, 1, 5'd4, t);
        send(enc_r(FN_ADD, 5'd4, 5'd0, 5'd6, 5'd0), 32'h308, 0);
        idle(1);
        retire(5'd4);
        idle(1);
        retire(5'd6);

        // ori/lui immediates, then flush of a stalled instruction
        send(enc_i(OP_ORI, 5'd0, 5'd5, 16'hFFFF), 32'h400, 0);
        idle(1);
        send(enc_i(OP_LUI, 5'd0, 5'd8, 16'hFFFF), 32'h404, 0);
        idle(1);
        send(enc_r(FN_ADD, 5'd5, 5'd8, 5'd9, 5'd0), 32'h408, 0);
        idle(2);
        step(1, enc_i(OP_ADDI, 5'd0, 5'd10, 16'd1), 32'h40C, 1, 1, 0, 5'd0, t);
        idle(2);
        retire(5'd5);
        retire(5'd8);

        // illegal encodings, r0 destination, store and branch
        send(enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h500, 0);
        idle(1);
        send(enc_r(FN_ADD, 5'd1, 5'd2, 5'd0, 5'd0), 32'h504, 0);
        idle(1);
        send(enc_r(6'h3E, 5'd1, 5'd2, 5'd3, 5'd0), 32'h508, 0);
        idle(1);
        send(enc_i(OP_SW, 5'd2, 5'd3, 16'd4), 32'h50C, 0);
        idle(1);
        send(enc_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFF), 32'h510, 0);
        idle(1);

        // asynchronous reset while a consumer is stalled
        send(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7), 32'h600, 0);
        idle(1);
        send(enc_r(FN_ADD, 5'd1, 5'd1, 5'd2, 5'd0), 32'h604, 0);
        idle(2);
        rst_n = 0;
        q.delete();
        foreach (pend[i]) pend[i] = 0;
        idle(2);
        rst_n = 1;
        send(enc_r(FN_ADD, 5'd1, 5'd1, 5'd2, 5'd0), 32'h700, 0);
        idle(1);
        retire(5'd2);

        // randomized traffic with backpressure, flushes and writebacks
        for (int i = 0; i < 300; i++) send(rand_instr(), 32'h1000 + 32'(4 * i), 1);
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
